mode7_affine_seq: RTL

Sequencer that evaluates the Mode 7 affine transform for one screen coordinate by time-sharing a single combinational sign-magnitude fixed-point multiplier (multiply_fp) across the four matrix products. It sits between the scanline coordinate generator and the texture address stage. Per request it computes u = A·(sx−x0) + B·(sy−y0) + x0 and v = C·(sx−x0) + D·(sy−y0) + y0. Results are returned on a start/done handshake at fixed latency.

---
 rtl/mode7_affine_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mode7_affine_seq.sv
// Mode 7 affine sequencer: u/v = M*(s - centre) + centre, sharing one external
// sign-magnitude multiplier across the four matrix products (8-cycle cadence).
module mode7_affine_seq #(
    parameter int SIZE = 24,
    parameter int FRAC = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    output logic            o_ready,
    input  logic [SIZE-1:0] i_mat_a,
    input  logic [SIZE-1:0] i_mat_b,
    input  logic [SIZE-1:0] i_mat_c,
    input  logic [SIZE-1:0] i_mat_d,
    input  logic [SIZE-1:0] i_x0,
    input  logic [SIZE-1:0] i_y0,
    input  logic [SIZE-1:0] i_sx,
    input  logic [SIZE-1:0] i_sy,
    output logic [SIZE-1:0] o_mul_a,
    output logic [SIZE-1:0] o_mul_b,
    input  logic [SIZE-1:0] i_mul_p,
    output logic [SIZE-1:0] o_u,
    output logic [SIZE-1:0] o_v,
    output logic            o_out_valid,
    output logic            o_ovf
);

    localparam int MW = SIZE - 1;

    if (FRAC < 0 || FRAC > MW) begin : gBadFrac
        $error("mode7_affine_seq: FRAC must lie within the magnitude field");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_DIFF, S_MUL0, S_MUL1, S_MUL2, S_MUL3, S_SUM, S_DONE
    } state_t;

    // Returns {overflow, sign, magnitude}; negative zero in is zero, zero out is positive.
    function automatic logic [SIZE:0] smAdd(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        logic [MW-1:0] ma, mb, mr;
        logic          sa, sb, sr, of;
        logic [MW:0]   sum;
        ma  = a[MW-1:0];
        mb  = b[MW-1:0];
        sa  = a[SIZE-1] && (ma != '0);
        sb  = b[SIZE-1] && (mb != '0);
        of  = 1'b0;
        sum = {1'b0, ma} + {1'b0, mb};
        if (sa == sb) begin
            sr = sa;
            if (sum[MW]) begin
                mr = '1;
                of = 1'b1;
            end else begin
                mr = sum[MW-1:0];
            end
        end else if (ma >= mb) begin
            sr = sa;
            mr = ma - mb;
        end else begin
            sr = sb;
            mr = mb - ma;
        end
        if (mr == '0) sr = 1'b0;
        return {of, sr, mr};
    endfunction

    function automatic logic [SIZE:0] smSub(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        return smAdd(a, {~b[SIZE-1], b[MW-1:0]});
    endfunction

    state_t          r_state, w_stateNext;
    logic [SIZE-1:0] r_matA, r_matB, r_matC, r_matD, r_x0, r_y0, r_sx, r_sy;
    logic [SIZE-1:0] r_dx, r_dy, r_accU, r_accV, r_u, r_v, r_mulA, r_mulB;
    logic [SIZE-1:0] w_mulANext, w_mulBNext;
    logic            r_ovfAcc, r_ovf, r_outValid, w_ready;
    logic [SIZE:0]   w_diffX, w_diffY, w_accUAdd, w_accVAdd, w_sumU, w_sumV;

    assign w_diffX   = smSub(r_sx, r_x0);
    assign w_diffY   = smSub(r_sy, r_y0);
    assign w_accUAdd = smAdd(r_accU, i_mul_p);
    assign w_accVAdd = smAdd(r_accV, i_mul_p);
    assign w_sumU    = smAdd(r_accU, r_x0);
    assign w_sumV    = smAdd(r_accV, r_y0);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_stateNext;
    end

    // Operands are registered one state ahead so they are stable for the whole MUL cycle.
    always_comb begin
        w_stateNext = r_state;
        w_ready     = 1'b0;
        w_mulANext  = '0;
        w_mulBNext  = '0;
        unique case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (i_start) w_stateNext = S_DIFF;
            end
            S_DIFF: begin
                w_stateNext = S_MUL0;
                w_mulANext  = r_matA;
                w_mulBNext  = w_diffX[SIZE-1:0];
            end
            S_MUL0: begin
                w_stateNext = S_MUL1;
                w_mulANext  = r_matB;
                w_mulBNext  = r_dy;
            end
            S_MUL1: begin
                w_stateNext = S_MUL2;
                w_mulANext  = r_matC;
                w_mulBNext  = r_dx;
            end
            S_MUL2: begin
                w_stateNext = S_MUL3;
                w_mulANext  = r_matD;
                w_mulBNext  = r_dy;
            end
            S_MUL3: w_stateNext = S_SUM;
            S_SUM:  w_stateNext = S_DONE;
            S_DONE: w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_matA <= '0; r_matB <= '0; r_matC <= '0; r_matD <= '0;
            r_x0 <= '0; r_y0 <= '0; r_sx <= '0; r_sy <= '0;
            r_dx <= '0; r_dy <= '0; r_accU <= '0; r_accV <= '0;
            r_u <= '0; r_v <= '0; r_mulA <= '0; r_mulB <= '0;
            r_ovfAcc <= 1'b0; r_ovf <= 1'b0; r_outValid <= 1'b0;
        end else begin
            r_mulA     <= w_mulANext;
            r_mulB     <= w_mulBNext;
            r_outValid <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_matA <= i_mat_a; r_matB <= i_mat_b; r_matC <= i_mat_c; r_matD <= i_mat_d;
                    r_x0 <= i_x0; r_y0 <= i_y0; r_sx <= i_sx; r_sy <= i_sy;
                    r_ovfAcc <= 1'b0;
                end
                S_DIFF: begin
                    r_dx     <= w_diffX[SIZE-1:0];
                    r_dy     <= w_diffY[SIZE-1:0];
                    r_ovfAcc <= r_ovfAcc | w_diffX[SIZE] | w_diffY[SIZE];
                end
                S_MUL0: r_accU <= i_mul_p;
                S_MUL1: begin
                    r_accU   <= w_accUAdd[SIZE-1:0];
                    r_ovfAcc <= r_ovfAcc | w_accUAdd[SIZE];
                end
                S_MUL2: r_accV <= i_mul_p;
                S_MUL3: begin
                    r_accV   <= w_accVAdd[SIZE-1:0];
                    r_ovfAcc <= r_ovfAcc | w_accVAdd[SIZE];
                end
                S_SUM: begin
                    r_accU   <= w_sumU[SIZE-1:0];
                    r_accV   <= w_sumV[SIZE-1:0];
                    r_ovfAcc <= r_ovfAcc | w_sumU[SIZE] | w_sumV[SIZE];
                end
                S_DONE: begin
                    r_u        <= r_accU;
                    r_v        <= r_accV;
                    r_ovf      <= r_ovfAcc;
                    r_outValid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_ready     = w_ready;
    assign o_mul_a     = r_mulA;
    assign o_mul_b     = r_mulB;
    assign o_u         = r_u;
    assign o_v         = r_v;
    assign o_ovf       = r_ovf;
    assign o_out_valid = r_outValid;

endmodule
